// File: rtl/apb_periph_pkg.sv
// rtl/apb_periph_pkg.sv - shared address decode constants for apb_periph_pair
package apb_periph_pkg;

  localparam int SEL_LSB = 13;
  localparam int SEL_MSB = 14;
  localparam logic [1:0] RAM_SEL = 2'b11;

  localparam int WORD_IDX_W = 11;
  typedef logic [WORD_IDX_W-1:0] word_idx_t;

  localparam word_idx_t OFF_OPA    = 11'd0;
  localparam word_idx_t OFF_OPB    = 11'd1;
  localparam word_idx_t OFF_SUM    = 11'd2;
  localparam word_idx_t OFF_STATUS = 11'd3;

  localparam logic [31:0] DEFAULT_RDATA = 32'h0000_00AF;

endpackage

// File: rtl/apb_adder_core.sv
// rtl/apb_adder_core.sv - zero-wait-state APB completer with two operands, sum and carry
module apb_adder_core
  import apb_periph_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [10:0] offset,
  input  logic [31:0] pwdata,
  output logic [31:0] prdata,
  output logic        pready,
  output logic        pslverr
);

  logic [31:0] opa;
  logic [31:0] opb;
  logic [32:0] sum_full;
  logic        illegal;
  logic        wr_en;

  assign sum_full = {1'b0, opa} + {1'b0, opb};

  always_comb begin
    prdata  = 32'h0;
    illegal = 1'b0;
    case (offset)
      OFF_OPA:    prdata = opa;
      OFF_OPB:    prdata = opb;
      OFF_SUM: begin
        prdata  = sum_full[31:0];
        illegal = pwrite;
      end
      OFF_STATUS: begin
        prdata  = {31'd0, sum_full[32]};
        illegal = pwrite;
      end
      default:    illegal = 1'b1;
    endcase
  end

  assign wr_en = psel & penable & pwrite & ~illegal;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      opa <= 32'h0;
      opb <= 32'h0;
    end else if (wr_en) begin
      case (offset)
        OFF_OPA: opa <= pwdata;
        OFF_OPB: opb <= pwdata;
        default: ;
      endcase
    end
  end

  assign pready  = 1'b1;
  assign pslverr = psel & penable & illegal;

endmodule

// File: rtl/apb_ram_core.sv
// rtl/apb_ram_core.sv - zero-wait-state APB completer around a 32-bit single-port RAM
module apb_ram_core
  import apb_periph_pkg::*;
#(
  parameter int unsigned RAM_DEPTH = 256
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [10:0] word_idx,
  input  logic [31:0] pwdata,
  output logic [31:0] prdata,
  output logic        pready,
  output logic        pslverr
);

  localparam int AW = $clog2(RAM_DEPTH);

  logic [31:0] mem [RAM_DEPTH];
  logic        in_range;
  logic        wr_en;

  assign in_range = (32'(word_idx) < RAM_DEPTH);
  assign wr_en    = resetn & psel & penable & pwrite & in_range;

  // Contents deliberately survive reset; only the write is gated by it.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[word_idx[AW-1:0]] <= pwdata;
    end
  end

  assign prdata  = in_range ? mem[word_idx[AW-1:0]] : 32'h0;
  assign pready  = 1'b1;
  assign pslverr = psel & penable & ~in_range;

endmodule

// File: rtl/apb_periph_pair.sv
// rtl/apb_periph_pair.sv - APB leaf decoding a RAM and an adder peripheral
module apb_periph_pair
  import apb_periph_pkg::*;
#(
  parameter int unsigned RAM_DEPTH = 256
) (
  input  logic        PCLK,
  input  logic        PRESETn,
  input  logic [31:0] PADDR,
  input  logic        PWRITE,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR
);

  logic        hit_ram;
  logic        ram_sel;
  logic        adder_sel;
  word_idx_t   word_idx;
  logic [31:0] ram_rdata;
  logic        ram_ready;
  logic        ram_err;
  logic [31:0] adder_rdata;
  logic        adder_ready;
  logic        adder_err;
  logic        unused_addr;

  assign hit_ram     = (PADDR[SEL_MSB:SEL_LSB] == RAM_SEL);
  assign ram_sel     = PSEL & hit_ram;
  assign adder_sel   = PSEL & ~hit_ram;
  assign word_idx    = PADDR[12:2];
  assign unused_addr = &{1'b0, PADDR[31:15], PADDR[1:0]};

  apb_ram_core #(
    .RAM_DEPTH(RAM_DEPTH)
  ) u_ram (
    .clk      (PCLK),
    .resetn   (PRESETn),
    .psel     (ram_sel),
    .penable  (PENABLE),
    .pwrite   (PWRITE),
    .word_idx (word_idx),
    .pwdata   (PWDATA),
    .prdata   (ram_rdata),
    .pready   (ram_ready),
    .pslverr  (ram_err)
  );

  apb_adder_core u_adder (
    .clk      (PCLK),
    .resetn   (PRESETn),
    .psel     (adder_sel),
    .penable  (PENABLE),
    .pwrite   (PWRITE),
    .offset   (word_idx),
    .pwdata   (PWDATA),
    .prdata   (adder_rdata),
    .pready   (adder_ready),
    .pslverr  (adder_err)
  );

  always_comb begin
    PRDATA  = DEFAULT_RDATA;
    PREADY  = 1'b1;
    PSLVERR = 1'b0;
    if (ram_sel) begin
      PRDATA  = ram_rdata;
      PREADY  = ram_ready;
      PSLVERR = ram_err;
    end else if (adder_sel) begin
      PRDATA  = adder_rdata;
      PREADY  = adder_ready;
      PSLVERR = adder_err;
    end
  end

endmodule

// File: tb/tb_apb_periph_pair.sv
// tb/tb_apb_periph_pair.sv - directed vector bench for apb_periph_pair
module tb_apb_periph_pair;

  logic        PCLK;
  logic        PRESETn;
  logic [31:0] PADDR;
  logic        PWRITE;
  logic        PSEL;
  logic        PENABLE;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  int checks;
  int failures;

  apb_periph_pair #(.RAM_DEPTH(256)) dut (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .PADDR   (PADDR),
    .PWRITE  (PWRITE),
    .PSEL    (PSEL),
    .PENABLE (PENABLE),
    .PWDATA  (PWDATA),
    .PRDATA  (PRDATA),
    .PREADY  (PREADY),
    .PSLVERR (PSLVERR)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic err, output logic rdy);
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wdata;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    #3;
    rdata = PRDATA; err = PSLVERR; rdy = PREADY;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  logic [31:0] rd;
  logic        er;
  logic        ry;

  initial begin
    checks = 0; failures = 0;
    PRESETn = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = 32'h0; PWDATA = 32'h0;

    vecs.push_back('{1'b0, 32'h0000_0000, 32'h0,         32'h0000_0000, 1'b0});
    vecs.push_back('{1'b0, 32'h0000_0004, 32'h0,         32'h0000_0000, 1'b0});
    vecs.push_back('{1'b1, 32'h0000_0000, 32'h0000_0005, 32'h0,         1'b0});
    vecs.push_back('{1'b1, 32'h0000_0004, 32'h0000_0007, 32'h0,         1'b0});
    vecs.push_back('{1'b0, 32'h0000_0008, 32'h0,         32'h0000_000C, 1'b0});
    vecs.push_back('{1'b0, 32'h0000_000C, 32'h0,         32'h0000_0000, 1'b0});
    vecs.push_back('{1'b1, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0,         1'b0});
    vecs.push_back('{1'b1, 32'h0000_0004, 32'h0000_0001, 32'h0,         1'b0});
    vecs.push_back('{1'b0, 32'h0000_0008, 32'h0,         32'h0000_0000, 1'b0});
    vecs.push_back('{1'b0, 32'h0000_000C, 32'h0,         32'h0000_0001, 1'b0});
    vecs.push_back('{1'b1, 32'h0000_0008, 32'h0000_1234, 32'h0,         1'b1});
    vecs.push_back('{1'b0, 32'h0000_0008, 32'h0,         32'h0000_0000, 1'b0});
    vecs.push_back('{1'b1, 32'h0000_000C, 32'h0000_0001, 32'h0,         1'b1});
    vecs.push_back('{1'b0, 32'h0000_0010, 32'h0,         32'h0000_0000, 1'b1});
    vecs.push_back('{1'b1, 32'h0000_6004, 32'hDEAD_BEEF, 32'h0,         1'b0});
    vecs.push_back('{1'b1, 32'h0000_6008, 32'h1234_5678, 32'h0,         1'b0});
    vecs.push_back('{1'b0, 32'h0000_6008, 32'h0,         32'h1234_5678, 1'b0});
    vecs.push_back('{1'b0, 32'h0000_6004, 32'h0,         32'hDEAD_BEEF, 1'b0});
    vecs.push_back('{1'b1, 32'h0000_63FC, 32'h0BAD_F00D, 32'h0,         1'b0});
    vecs.push_back('{1'b0, 32'h0000_63FC, 32'h0,         32'h0BAD_F00D, 1'b0});
    vecs.push_back('{1'b1, 32'h0000_6400, 32'h0000_0005, 32'h0,         1'b1});
    vecs.push_back('{1'b0, 32'h0000_6400, 32'h0,         32'h0000_0000, 1'b1});
    vecs.push_back('{1'b0, 32'h8000_0004, 32'h0,         32'h0000_0001, 1'b0});
    vecs.push_back('{1'b0, 32'h8000_6004, 32'h0,         32'hDEAD_BEEF, 1'b0});
    vecs.push_back('{1'b0, 32'h0000_0000, 32'h0,         32'hFFFF_FFFF, 1'b0});

    repeat (3) @(posedge PCLK);
    #1;
    chk("reset_idle_prdata", PRDATA, 32'h0000_00AF);
    chk("reset_idle_pready", {31'd0, PREADY}, 32'd1);
    chk("reset_idle_pslverr", {31'd0, PSLVERR}, 32'd0);
    PRESETn = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      apb_xfer(vecs[i].wr, vecs[i].addr, vecs[i].wdata, rd, er, ry);
      if (!vecs[i].wr) chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
      chk($sformatf("vec%0d_pslverr", i), {31'd0, er}, {31'd0, vecs[i].exp_err});
      chk($sformatf("vec%0d_pready", i), {31'd0, ry}, 32'd1);
    end

    // Setup phase alone must not commit a write.
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h4; PWDATA = 32'h99;
    repeat (2) @(posedge PCLK);
    #1;
    chk("setup_only_pslverr", {31'd0, PSLVERR}, 32'd0);
    PSEL = 1'b0; PWRITE = 1'b0;
    apb_xfer(1'b0, 32'h4, 32'h0, rd, er, ry);
    chk("setup_only_opb", rd, 32'h0000_0001);

    // Back-to-back: write OPA then read SUM in the very next setup phase.
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h0; PWDATA = 32'h10;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(posedge PCLK); #1;
    PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 32'h8;
    #3;
    chk("b2b_sum_setup", PRDATA, 32'h0000_0011);
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    #3;
    chk("b2b_sum_access", PRDATA, 32'h0000_0011);
    @(posedge PCLK); #1;
    PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h6010; PWDATA = 32'h0000_CAFE;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(posedge PCLK); #1;
    PENABLE = 1'b0; PWRITE = 1'b0;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    #3;
    chk("b2b_ram_raw", PRDATA, 32'h0000_CAFE);
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;

    // RAM write attempted during reset must be dropped; contents survive reset.
    apb_xfer(1'b1, 32'h6000, 32'hA5A5_0001, rd, er, ry);
    PRESETn = 1'b0;
    apb_xfer(1'b1, 32'h6000, 32'h1111_1111, rd, er, ry);
    PRESETn = 1'b1;
    apb_xfer(1'b0, 32'h6000, 32'h0, rd, er, ry);
    chk("ram_write_in_reset", rd, 32'hA5A5_0001);
    apb_xfer(1'b0, 32'h0, 32'h0, rd, er, ry);
    chk("reset_clears_opa", rd, 32'h0);
    apb_xfer(1'b0, 32'h4, 32'h0, rd, er, ry);
    chk("reset_clears_opb", rd, 32'h0);

    // Reset landing in the middle of an OPA write aborts it.
    apb_xfer(1'b1, 32'h0, 32'h77, rd, er, ry);
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h0; PWDATA = 32'h55;
    PRESETn = 1'b0;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PRESETn = 1'b1;
    apb_xfer(1'b0, 32'h0, 32'h0, rd, er, ry);
    chk("midxfer_reset_opa", rd, 32'h0);

    #2;
    chk("idle_default_prdata", PRDATA, 32'h0000_00AF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
